writeback_regfile: RTL
======================

WRITEBACK_REGFILE -- requirements
Module: writeback_regfile

Interface
REQ-001 SHALL have parameter NUM_REGS, default 16, meaning architectural register count (R0..R15; R15 is the PC view).
REQ-002 SHALL have these ports (name  direction  width  meaning):
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- wb_control_in  input  4  WB control word driven by the MEM/WB pipeline register.
  - [0] rf_enable
  - [1] load_select
  - [2] flags_write
  - [3] byte_load
- wb_alu_result  input  32  ALU result latched in MEM/WB.
- wb_mem_data  input  32  memory read data latched in MEM/WB.
- wb_rd  input  4  destination register index.
- wb_flags_in  input  4  N,Z,C,V from the executing instruction.
- pc_plus8_in  input  32  current PC+8 value, returned on reads of R15.
- ra_addr, rb_addr, rc_addr  input  4 each  read port addresses for ID stage.
- ra_data, rb_data, rc_data  output  32 each  read port data.
- flags_out  output  4  architectural N,Z,C,V register.
- wb_data_out  output  32  selected writeback value this cycle, combinational, for forwarding.
- pc_write_ignored  output  1  sticky error flag.

Function
REQ-003 SHALL compute wb_data_out combinationally:
- load_select=0: wb_data_out = wb_alu_result.
- load_select=1 and byte_load=0: wb_data_out = wb_mem_data.
- load_select=1 and byte_load=1: wb_data_out = {24'b0, wb_mem_data[7:0]}.
- byte_load SHALL be ignored when load_select=0.
REQ-004 SHALL write wb_data_out into register wb_rd on the rising clk edge when rf_enable=1 and wb_rd != 15.
REQ-005 SHALL NOT modify any register when rf_enable=1 and wb_rd=15; pc_write_ignored SHALL instead be set to 1 on that edge and SHALL remain 1 until reset.
REQ-006 SHALL load flags_out from wb_flags_in on the rising edge when flags_write=1, independently of rf_enable; otherwise flags_out SHALL hold.
REQ-007 SHALL drive each read port combinationally, with priority:
- address 15: pc_plus8_in, regardless of any pending write.
- address equal to wb_rd while rf_enable=1: wb_data_out (same-cycle write-through bypass, zero-cycle latency).
- otherwise: stored register contents.
REQ-008 SHALL let all three read ports address the same register simultaneously, each returning identical data.
REQ-009 SHALL give a write at edge N visibility from stored contents from cycle N+1 onward; write-to-read latency seen by ID is 0 cycles via REQ-007.
REQ-010 SHALL treat an all-zero wb_control_in (bubble/flush) as a no-op: no register, flag or error-flag change.
REQ-011 SHALL NOT gate rf_enable and flags_write against each other; both may update on the same edge.

Reset
REQ-012 SHALL, while reset=1 and independent of clk, hold R0..R14 at 32'h0, flags_out at 4'h0 and pc_write_ignored at 0.
REQ-013 SHALL ignore any write in progress when reset asserts mid-cycle; no write at an edge coinciding with reset=1 takes effect.
REQ-014 SHALL keep read ports combinational during reset: 0 for R0..R14, pc_plus8_in for R15, or wb_data_out via bypass if rf_enable=1.
REQ-015 SHALL resume normal writes on the first rising edge after reset deasserts.

Verification
REQ-016 Basic write: reset, then wb_control_in=4'b0001, wb_rd=3, wb_alu_result=32'hDEADBEEF, one edge -> ra_addr=3 returns 32'hDEADBEEF; all other registers remain 0.
REQ-017 Byte load and bypass: wb_control_in=4'b1011, wb_mem_data=32'h12345687, wb_rd=5, ra_addr=rb_addr=5 before the edge -> both ports return 32'h00000087 combinationally, and R5=32'h00000087 after the edge.
REQ-018 PC protection: wb_control_in=4'b0001, wb_rd=15, pc_plus8_in=32'h108 -> rc_addr=15 returns 32'h108 and pc_write_ignored=1 after the edge; R0..R14 unchanged.
REQ-019 Flags only: wb_control_in=4'b0100, wb_flags_in=4'b1010, wb_rd=2 -> flags_out=4'b1010 after the edge; R2 unchanged.
REQ-020 Async reset: load R7=32'h5, assert reset between edges -> R7 reads 0 and flags_out=0 before the next edge; a write presented with reset still high is discarded.
REQ-021 Bubble: wb_control_in=4'b0000 for 4 cycles with random data and addresses -> no state change, pc_write_ignored remains 0.

Source files
------------

// File: rtl/writeback_regfile.sv
// Writeback stage and architectural register file.
// Selects the writeback value (ALU result, load word or zero-extended load
// byte), writes it into R0..R14, protects R15 (the PC view), maintains the
// N,Z,C,V flag register and a sticky error flag for attempted PC writes.
// Three combinational read ports bypass the value being written this cycle.
module writeback_regfile #(
   parameter int NUM_REGS = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  wb_control_in,
   input  logic [31:0] wb_alu_result,
   input  logic [31:0] wb_mem_data,
   input  logic [3:0]  wb_rd,
   input  logic [3:0]  wb_flags_in,
   input  logic [31:0] pc_plus8_in,
   input  logic [3:0]  ra_addr,
   input  logic [3:0]  rb_addr,
   input  logic [3:0]  rc_addr,
   output logic [31:0] ra_data,
   output logic [31:0] rb_data,
   output logic [31:0] rc_data,
   output logic [3:0]  flags_out,
   output logic [31:0] wb_data_out,
   output logic        pc_write_ignored
);

   // Index of the PC view; it has no storage and is never written.
   localparam logic [3:0] PC_IDX = 4'(NUM_REGS - 1);

   logic [31:0] regs_q [0:NUM_REGS-1];
   logic [3:0]  flags_q;
   logic [3:0]  flags_d;
   logic        pc_err_q;
   logic        pc_err_d;

   logic        rf_enable_s;
   logic        load_select_s;
   logic        flags_write_s;
   logic        byte_load_s;
   logic        reg_write_s;
   logic [31:0] wb_value_s;

   assign rf_enable_s   = wb_control_in[0];
   assign load_select_s = wb_control_in[1];
   assign flags_write_s = wb_control_in[2];
   assign byte_load_s   = wb_control_in[3];

   // Read mux: PC view first, then same-cycle bypass, then stored contents.
   function automatic logic [31:0] read_mux(
      input logic [3:0]  addr,
      input logic [31:0] stored,
      input logic [31:0] pc_view,
      input logic        rf_en,
      input logic [3:0]  rd,
      input logic [31:0] wb_value
   );
      logic [31:0] result;
      if (addr == PC_IDX) begin
         result = pc_view;
      end else if (rf_en && (addr == rd)) begin
         result = wb_value;
      end else begin
         result = stored;
      end
      return result;
   endfunction

   // Writeback value selection; byte_load only matters for loads.
   always_comb begin
      wb_value_s = wb_alu_result;
      if (!load_select_s) begin
         wb_value_s = wb_alu_result;
      end else if (byte_load_s) begin
         wb_value_s = {24'h000000, wb_mem_data[7:0]};
      end else begin
         wb_value_s = wb_mem_data;
      end
   end

   // Next-state for flags and the sticky PC-write error flag.
   always_comb begin
      flags_d     = flags_q;
      pc_err_d    = pc_err_q;
      reg_write_s = 1'b0;
      if (flags_write_s) begin
         flags_d = wb_flags_in;
      end else begin
         flags_d = flags_q;
      end
      if (rf_enable_s && (wb_rd == PC_IDX)) begin
         pc_err_d    = 1'b1;
         reg_write_s = 1'b0;
      end else if (rf_enable_s) begin
         pc_err_d    = pc_err_q;
         reg_write_s = 1'b1;
      end else begin
         pc_err_d    = pc_err_q;
         reg_write_s = 1'b0;
      end
   end

   // Register array storage with asynchronous clear.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= 32'h0000_0000;
         end
      end else if (reg_write_s) begin
         regs_q[wb_rd] <= wb_value_s;
      end
   end

   // Flag register and sticky error flag with asynchronous clear.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         flags_q  <= 4'h0;
         pc_err_q <= 1'b0;
      end else begin
         flags_q  <= flags_d;
         pc_err_q <= pc_err_d;
      end
   end

   assign wb_data_out      = wb_value_s;
   assign flags_out        = flags_q;
   assign pc_write_ignored = pc_err_q;

   assign ra_data = read_mux(ra_addr, regs_q[ra_addr], pc_plus8_in, rf_enable_s, wb_rd, wb_value_s);
   assign rb_data = read_mux(rb_addr, regs_q[rb_addr], pc_plus8_in, rf_enable_s, wb_rd, wb_value_s);
   assign rc_data = read_mux(rc_addr, regs_q[rc_addr], pc_plus8_in, rf_enable_s, wb_rd, wb_value_s);

endmodule
